// File: rtl/inert_intf_multi_if.sv
// SPI-master handshake bundle between the inertial sensor reader and the
// SPI master: start strobe + command out, completion strobe + read data in.
interface inert_intf_multi_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;

  modport master (output wrt, output cmd, input done, input rd_data);
  modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

// File: rtl/inert_intf_multi.sv
// Inertial sensor reader: initialises the sensor with four register writes,
// then on each data-ready (INT) reads NUM_CH 16-bit channels one byte per
// SPI slot and publishes them atomically with a one-cycle vld strobe.
// Optional feature macro: INERT_SPIKE_FILT_EN zeroes out-of-range words.
module inert_intf_multi #(
  parameter int                  NUM_CH    = 2,
  parameter logic [NUM_CH*8-1:0] CH_ADDR   = {8'h2C, 8'h22},
  parameter int                  SLOT_BITS = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     INT,
  input  logic                     clr_err,
  inert_intf_multi_if.master       spi,
  output logic [NUM_CH*16-1:0]     ch_data,
  output logic                     vld,
  output logic                     ovr,
  output logic                     miss
);

  localparam int NB = 2 * NUM_CH;
  localparam int KW = $clog2(NB);

  typedef enum logic [2:0] {INIT0, INIT1, INIT2, INIT3, IDLE, READ} state_t;

  state_t                  state, state_nxt;
  logic                    int_meta, int_s, int_s_d;
  logic [15:0]             timer;
  logic                    se;
  logic [KW-1:0]           k, k_nxt;
  logic [7:0]              shadow [NB];
  logic [7:0]              shadow_nxt [NB];
  logic                    got_done;
  logic                    wrt_q, wrt_nxt;
  logic [15:0]             cmd_q, cmd_nxt;
  logic                    timer_clr, load, miss_set, ovr_set;
  logic [NUM_CH*16-1:0]    load_words;

  assign se      = &timer[SLOT_BITS-1:0];
  assign ovr_set = (state == READ) && int_s && !int_s_d;
  assign spi.wrt = wrt_q;
  assign spi.cmd = cmd_q;

  // Read command for byte idx: even bytes hit the channel's low-byte
  // register, odd bytes the register right above it.
  function automatic logic [15:0] rd_cmd(input logic [KW-1:0] idx);
    logic [7:0] base;
    logic [7:0] addr;
    base = 8'h00;
    for (int c = 0; c < NUM_CH; c++) begin
      if ((int'(idx) / 2) == c) base = CH_ADDR[8*c +: 8];
    end
    addr = base + {7'b0, idx[0]};
    return {1'b1, addr[6:0], 8'h00};
  endfunction

  // Optional spike filter applied as words are published.
  function automatic logic [15:0] filt(input logic [15:0] w);
`ifdef INERT_SPIKE_FILT_EN
    if ($signed(w) > 16'sh1F00 || $signed(w) < -16'sh1F00) return 16'h0000;
    return w;
`else
    return w;
`endif
  endfunction

  // Next-state, command issue and shadow-byte capture.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    wrt_nxt   = 1'b0;
    cmd_nxt   = 16'h0000;
    timer_clr = 1'b0;
    load      = 1'b0;
    miss_set  = 1'b0;
    for (int b = 0; b < NB; b++) shadow_nxt[b] = shadow[b];
    if (state == READ && spi.done) shadow_nxt[k] = spi.rd_data[7:0];
    case (state)
      INIT0: if (&timer) begin
        wrt_nxt = 1'b1; cmd_nxt = 16'h0D02; state_nxt = INIT1;
      end
      INIT1: if (se) begin
        wrt_nxt = 1'b1; cmd_nxt = 16'h1053; state_nxt = INIT2;
      end
      INIT2: if (se) begin
        wrt_nxt = 1'b1; cmd_nxt = 16'h1150; state_nxt = INIT3;
      end
      INIT3: if (se) begin
        wrt_nxt = 1'b1; cmd_nxt = 16'h1460; state_nxt = IDLE;
      end
      IDLE: if (int_s) begin
        wrt_nxt   = 1'b1;
        cmd_nxt   = rd_cmd('0);
        k_nxt     = '0;
        timer_clr = 1'b1;
        state_nxt = READ;
      end
      READ: if (se) begin
        if (!(got_done || spi.done)) miss_set = 1'b1;
        if (k == KW'(NB - 1)) begin
          state_nxt = IDLE;
          load      = 1'b1;
        end else begin
          wrt_nxt = 1'b1;
          cmd_nxt = rd_cmd(k + 1'b1);
          k_nxt   = k + 1'b1;
        end
      end
      default: state_nxt = INIT0;
    endcase
  end

  // Assemble the words to publish, including a byte captured this very cycle.
  always_comb begin
    load_words = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      load_words[16*c +: 16] = filt({shadow_nxt[2*c+1], shadow_nxt[2*c]});
    end
  end

  // Two-flop synchroniser for INT plus a delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      int_meta <= 1'b0;
      int_s    <= 1'b0;
      int_s_d  <= 1'b0;
    end else begin
      int_meta <= INT;
      int_s    <= int_meta;
      int_s_d  <= int_s;
    end
  end

  // Free-running slot timer, restarted at the start of each sample.
  always_ff @(posedge clk) begin
    if (rst || timer_clr) timer <= 16'h0000;
    else                  timer <= timer + 16'h0001;
  end

  // Control state, SPI command register, shadow bytes and slot done tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT0;
      k        <= '0;
      wrt_q    <= 1'b0;
      cmd_q    <= 16'h0000;
      got_done <= 1'b0;
      for (int b = 0; b < NB; b++) shadow[b] <= 8'h00;
    end else begin
      state    <= state_nxt;
      k        <= k_nxt;
      wrt_q    <= wrt_nxt;
      cmd_q    <= cmd_nxt;
      got_done <= (state == READ && !se) ? (got_done | spi.done) : 1'b0;
      for (int b = 0; b < NB; b++) shadow[b] <= shadow_nxt[b];
    end
  end

  // Publish a whole sample at once, with vld marking the update.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_data <= '0;
      vld     <= 1'b0;
    end else begin
      vld <= load;
      if (load) ch_data <= load_words;
    end
  end

  // Sticky error flags; a new event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr  <= 1'b0;
      miss <= 1'b0;
    end else begin
      if (ovr_set)      ovr <= 1'b1;
      else if (clr_err) ovr <= 1'b0;
      if (miss_set)     miss <= 1'b1;
      else if (clr_err) miss <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inert_intf_multi.sv
// Directed bench for inert_intf_multi with a behavioural SPI responder that
// returns bytes from a small register image a few cycles after each wrt.
module tb_inert_intf_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_in;
  logic        clr_err;
  logic [31:0] ch_data;
  logic        vld, ovr, miss;

  inert_intf_multi_if spi();

  inert_intf_multi #(
    .NUM_CH(2),
    .CH_ADDR({8'h2C, 8'h22}),
    .SLOT_BITS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .INT(int_in),
    .clr_err(clr_err),
    .spi(spi),
    .ch_data(ch_data),
    .vld(vld),
    .ovr(ovr),
    .miss(miss)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0]  reg_mem [0:127];
  logic [15:0] cmd_log [$];
  int          wrt_cyc [$];
  int          pend_cnt = 0;
  logic [6:0]  pend_addr = 7'h00;
  bit          pend_skip = 1'b0;
  bit          skip_en = 1'b0;
  logic [6:0]  skip_addr = 7'h00;
  int          vld_cnt = 0;
  logic [31:0] vld_data = 32'h0;
  int          stealth_chg = 0;
  logic [31:0] prev_ch;

  logic [15:0] exp_rd [4] = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

  // Cycle counter used to time the init writes.
  always @(posedge clk) cyc <= cyc + 1;

  // SPI responder: logs every wrt and answers with done four cycles later.
  initial begin
    spi.done    = 1'b0;
    spi.rd_data = 16'h0000;
    forever begin
      @(negedge clk);
      spi.done = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0 && !pend_skip) begin
          spi.done    = 1'b1;
          spi.rd_data = {8'hA5, reg_mem[pend_addr]};
        end
      end
      if (spi.wrt === 1'b1) begin
        cmd_log.push_back(spi.cmd);
        wrt_cyc.push_back(cyc);
        pend_cnt  = 4;
        pend_addr = spi.cmd[14:8];
        pend_skip = skip_en && spi.cmd[15] && (spi.cmd[14:8] == skip_addr);
      end
    end
  end

  // Output monitor: counts vld pulses and flags ch_data changes without vld.
  always @(negedge clk) begin
    if (vld === 1'b1) begin
      vld_cnt++;
      vld_data = ch_data;
    end
    if (rst === 1'b0 && ch_data !== prev_ch && vld !== 1'b1) stealth_chg++;
    prev_ch = ch_data;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // One sample: raise INT until the first read, optionally glitch INT
  // mid-sample, then check commands, vld count and published data.
  task automatic applyStimulus(input bit glitch, input logic [31:0] exp_data, input string tag);
    int base_cmd;
    int base_vld;
    base_cmd = cmd_log.size();
    base_vld = vld_cnt;
    int_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cmd_log.size() > base_cmd) break;
    end
    checkOutput({tag, "_start"}, 32'(cmd_log.size() > base_cmd), 32'd1);
    repeat (3) tick();
    int_in = 1'b0;
    if (glitch) begin
      repeat (15) tick();
      int_in = 1'b1;
      repeat (4) tick();
      int_in = 1'b0;
    end
    for (int i = 0; i < 150; i++) begin
      tick();
      if (vld_cnt > base_vld) break;
    end
    repeat (30) tick();
    checkOutput({tag, "_vld_cnt"}, 32'(vld_cnt - base_vld), 32'd1);
    checkOutput({tag, "_ncmd"}, 32'(cmd_log.size() - base_cmd), 32'd4);
    for (int j = 0; j < 4; j++)
      checkOutput($sformatf("%s_cmd%0d", tag, j), {16'h0, cmd_log[base_cmd + j]}, {16'h0, exp_rd[j]});
    checkOutput({tag, "_data"}, vld_data, exp_data);
  endtask

  task automatic pulseClr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tick();
  endtask

  initial begin
    int base_cmd;
    int base_vld;
    logic [31:0] exp_spike;
    rst     = 1'b1;
    int_in  = 1'b0;
    clr_err = 1'b0;
    for (int a = 0; a < 128; a++) reg_mem[a] = 8'h00;

    // Reset state
    repeat (3) tick();
    checkOutput("rst_wrt",  {31'h0, spi.wrt}, 32'h0);
    checkOutput("rst_cmd",  {16'h0, spi.cmd}, 32'h0);
    checkOutput("rst_vld",  {31'h0, vld}, 32'h0);
    checkOutput("rst_ovr",  {31'h0, ovr}, 32'h0);
    checkOutput("rst_miss", {31'h0, miss}, 32'h0);
    checkOutput("rst_data", ch_data, 32'h0);
    rst = 1'b0;

    // Init write sequence, one slot apart after the full timer wrap
    for (int i = 0; i < 70000; i++) begin
      tick();
      if (cmd_log.size() >= 4) break;
    end
    checkOutput("init_count", 32'(cmd_log.size()), 32'd4);
    checkOutput("init_cmd0", {16'h0, cmd_log[0]}, 32'h0D02);
    checkOutput("init_cmd1", {16'h0, cmd_log[1]}, 32'h1053);
    checkOutput("init_cmd2", {16'h0, cmd_log[2]}, 32'h1150);
    checkOutput("init_cmd3", {16'h0, cmd_log[3]}, 32'h1460);
    checkOutput("init_gap1", 32'(wrt_cyc[1] - wrt_cyc[0]), 32'd16);
    checkOutput("init_gap2", 32'(wrt_cyc[2] - wrt_cyc[1]), 32'd16);
    checkOutput("init_gap3", 32'(wrt_cyc[3] - wrt_cyc[2]), 32'd16);
    repeat (20) tick();
    checkOutput("idle_quiet", 32'(cmd_log.size()), 32'd4);

    // Plain sample
    reg_mem[7'h22] = 8'h34; reg_mem[7'h23] = 8'h12;
    reg_mem[7'h2C] = 8'h78; reg_mem[7'h2D] = 8'h56;
    applyStimulus(1'b0, 32'h5678_1234, "s1");
    checkOutput("s1_miss", {31'h0, miss}, 32'h0);
    checkOutput("s1_ovr",  {31'h0, ovr}, 32'h0);

    // Missing done on the channel 1 low byte keeps its previous value
    reg_mem[7'h22] = 8'h11; reg_mem[7'h23] = 8'h22;
    reg_mem[7'h2C] = 8'h99; reg_mem[7'h2D] = 8'h44;
    skip_en = 1'b1; skip_addr = 7'h2C;
    applyStimulus(1'b0, 32'h4478_2211, "s2");
    skip_en = 1'b0;
    checkOutput("s2_miss", {31'h0, miss}, 32'h1);
    pulseClr();
    checkOutput("s2_miss_clr", {31'h0, miss}, 32'h0);

    // INT re-asserted mid-sample sets overrun without restarting
    reg_mem[7'h22] = 8'hAA; reg_mem[7'h23] = 8'h0B;
    reg_mem[7'h2C] = 8'hCC; reg_mem[7'h2D] = 8'h0D;
    applyStimulus(1'b1, 32'h0DCC_0BAA, "s3");
    checkOutput("s3_ovr",  {31'h0, ovr}, 32'h1);
    checkOutput("s3_miss", {31'h0, miss}, 32'h0);
    pulseClr();
    checkOutput("s3_ovr_clr", {31'h0, ovr}, 32'h0);

    // Out-of-range words
    reg_mem[7'h22] = 8'h00; reg_mem[7'h23] = 8'h20;
    reg_mem[7'h2C] = 8'hFF; reg_mem[7'h2D] = 8'hE0;
`ifdef INERT_SPIKE_FILT_EN
    exp_spike = 32'h0000_0000;
`else
    exp_spike = 32'hE0FF_2000;
`endif
    applyStimulus(1'b0, exp_spike, "s4");
    checkOutput("no_partial_update", 32'(stealth_chg), 32'd0);

    // Reset during slot 3 abandons the sample and restarts init
    base_cmd = cmd_log.size();
    base_vld = vld_cnt;
    int_in = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cmd_log.size() >= base_cmd + 3) break;
    end
    checkOutput("mr_slot3", 32'(cmd_log.size() - base_cmd), 32'd3);
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();
    checkOutput("mr_wrt",  {31'h0, spi.wrt}, 32'h0);
    checkOutput("mr_cmd",  {16'h0, spi.cmd}, 32'h0);
    checkOutput("mr_vld",  {31'h0, vld}, 32'h0);
    checkOutput("mr_data", ch_data, 32'h0);
    checkOutput("mr_ovr",  {31'h0, ovr}, 32'h0);
    checkOutput("mr_miss", {31'h0, miss}, 32'h0);
    rst = 1'b0;
    repeat (200) tick();
    checkOutput("mr_no_vld", 32'(vld_cnt - base_vld), 32'd0);
    checkOutput("mr_no_wrt", 32'(cmd_log.size() - (base_cmd + 3)), 32'd0);
    checkOutput("mr_data_after", ch_data, 32'h0);
    int_in = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
